dram_unpacker: RTL and testbench
================================

// Module: dram_unpacker
// PURPOSE
//  Read-side counterpart of the sample packer. Fetches 128-bit words from the DRAM memory interface and
//  splits each into four 32-bit samples, delivered to the readback consumer over a valid/ready stream.
//  Sits between the memory interface read port and the host upload path.
// PARAMETERS
//  SAMPLE_PACKET_WIDTH  32   sample width; MEM_IF_WIDTH/SAMPLE_PACKET_WIDTH = 4 lanes per word
//  MEM_IF_WIDTH         128  memory interface data width
//  ADX_WIDTH            27   memory address width
//  MEMORY_WORD_WIDTH    2    memory word size in bytes; address step per 128-bit word = 8
// PORTS
//  clk              in   1    system clock, single clock domain
//  reset            in   1    synchronous, active-high reset
//  start            in   1    1-cycle pulse; latches first_sample/num_samples; ignored while busy=1
//  first_sample     in   32   index of first sample to return
//  num_samples      in   32   number of samples to return
//  busy             out  1    high from accepted start until done
//  done             out  1    1-cycle pulse after the last sample handshake
//  sample_data      out  32   sample output, registered
//  sample_valid     out  1    sample_data valid
//  sample_ready     in   1    consumer accepts when sample_valid && sample_ready
//  dram_adx         out  27   read address, registered; word-aligned (low 3 bits 0)
//  read_req         out  1    read command; may assert only in a cycle where read_allowed=1
//  read_allowed     in   1    memory interface can accept a command this cycle
//  read_data        in   128  read return data; lane k = bits[32k+31:32k], lane 0 = oldest sample
//  read_data_valid  in   1    1-cycle strobe; exactly one beat per accepted read_req
// BEHAVIOUR
//  Reset: busy, done, sample_valid, read_req = 0; sample_data = 0; dram_adx = 0. Lane pointer, counters,
//   buffer and outstanding flag cleared. A read_data_valid with no request outstanding is dropped.
//  Address: word index w = sample >> 2; dram_adx = (w * 8) mod 2^ADX_WIDTH, using the sampleToAdx module.
//   Consecutive words increment by 8 and wrap silently at 2^ADX_WIDTH.
//  Fetch FSM: F_IDLE -> (start, num_samples != 0) F_REQ -> (read_allowed) F_WAIT -> (read_data_valid) F_IDLE
//   or F_REQ. read_req = (state==F_REQ) && read_allowed. The command is accepted that same cycle.
//   At most one request outstanding. A new request is issued only when a buffer slot is free and words remain.
//  Drain: the first word starts at lane first_sample[1:0]; leading lanes are skipped. Lanes are emitted
//   in order 0..3. After the final sample, remaining lanes of the last word are discarded.
//  Latency: start -> read_req at earliest cycle +1. read_data_valid -> sample_valid at cycle +1
//   (buffer empty, consumer ready).
//  Stream: sample_valid is held until handshake. sample_data is stable while valid && !ready.
//   One sample per cycle is sustained under continuous ready.
//  Boundaries:
//   - num_samples == 0: busy stays 0, no read issued, done pulses the cycle after start.
//   - start while busy: ignored, parameters unchanged.
//   - read_data_valid and the last-lane handshake in the same cycle: both take effect, no data loss.
//   - reset mid-transfer: everything aborts to reset values; no done pulse.
//   - done asserts the cycle after the final handshake; busy falls the same cycle.
// CONFIGURATION
//  DRAM_UNPACKER_PREFETCH_EN defined: two-word buffer. The next word is requested as soon as the current
//   word is loaded, hiding read latency.
//  Not defined: one-word buffer. The next read_req is issued only after the last lane of the current word
//   has been handed off.
//  Both builds: one outstanding request, same port list.
// STRUCTURE
//  dram_if_pkg holds shared constants: LANES=4, ADX_STEP=8, lane index width, fetch-state encodings.
//  Sub-module dram_word_buffer: 1- or 2-entry 128-bit FIFO with lane pointer and pop-lane interface.
//  Address conversion reuses the existing sampleToAdx.
// TESTING
//  1. first_sample=0, num_samples=8, ready=1, 3-cycle read latency -> adx 0 then 8; samples 0..7 in lane order; done once.
//  2. first_sample=6, num_samples=3 -> adx 8 then 16; lanes 2,3 of word 1 then lane 0 of word 2; rest discarded.
//  3. num_samples=0 -> no read_req; done pulse the cycle after start; busy never high.
//  4. read_allowed low for 5 cycles -> read_req stays 0; request issued in the first allowed cycle; data intact.
//  5. sample_ready toggling randomly -> sample_data stable while stalled; no drops or duplicates (scoreboard).
//  6. reset during F_WAIT, then a stale read_data_valid -> strobe dropped; all outputs at reset values.
//     With PREFETCH_EN: second read_req before the first lane handoff.

Source files
------------

// File: rtl/dram_if_pkg.sv
// -----------------------------------------------------------------------------
// dram_if_pkg
// Constants and types shared by the DRAM read-side unpacker:
//   LANES      - 32-bit samples per 128-bit memory word
//   LANE_W     - width of a lane index
//   ADX_STEP   - address increment between consecutive 128-bit words
//   fetch_state_t - read-command FSM encodings
// -----------------------------------------------------------------------------
package dram_if_pkg;

  localparam int LANES    = 4;
  localparam int LANE_W   = 2;
  localparam int ADX_STEP = 8;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/dram_word_buffer.sv
// -----------------------------------------------------------------------------
// dram_word_buffer
// 1- or 2-entry FIFO of 128-bit words with a per-entry lane pointer. Samples
// are popped one lane at a time from the head word; the word is retired after
// lane 3 or when the caller flags the final sample. An empty buffer bypasses
// the incoming word straight to the head so a lane can leave the same cycle
// it arrives.
// Ports:
//   clk, reset   in   clock, synchronous active-high reset
//   push         in   store push_data (caller guarantees a free slot)
//   push_data    in   128-bit word
//   push_lane    in   first lane to emit from this word
//   pop          in   consume the head lane
//   pop_last     in   this pop is the final sample; retire the head word
//   avail        out  a head lane is available (stored or bypassed)
//   slot_free    out  after this cycle at least one entry is free
//   head_sample  out  current head lane
// -----------------------------------------------------------------------------
module dram_word_buffer
  import dram_if_pkg::*;
#(
  parameter int DEPTH    = 1,
  parameter int WORD_W   = 128,
  parameter int SAMPLE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WORD_W-1:0]   push_data,
  input  logic [LANE_W-1:0]   push_lane,
  input  logic                pop,
  input  logic                pop_last,
  output logic                avail,
  output logic                slot_free,
  output logic [SAMPLE_W-1:0] head_sample
);

  logic [WORD_W-1:0] mem      [2];
  logic [LANE_W-1:0] lane_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count, count_next;

  logic              bypass, release_word, store, retire, lane_step;
  logic [WORD_W-1:0] cur_word;
  logic [LANE_W-1:0] cur_lane;

  // Pointers stay at entry 0 in the single-entry build.
  function automatic logic next_ptr(input logic p);
    return (DEPTH > 1) ? ~p : 1'b0;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bypass       = (count == 2'd0);
    cur_word     = bypass ? push_data : mem[rd_ptr];
    cur_lane     = bypass ? push_lane : lane_mem[rd_ptr];
    avail        = !bypass || push;
    release_word = pop && ((cur_lane == LANE_W'(LANES - 1)) || pop_last);
    // A bypassed word that is fully consumed on arrival never occupies a slot.
    store        = push && !(bypass && release_word);
    retire       = !bypass && release_word;
    lane_step    = !bypass && pop && !release_word;
    count_next   = count + {1'b0, store} - {1'b0, retire};
    slot_free    = int'(count_next) < DEPTH;
    head_sample  = cur_word[cur_lane*SAMPLE_W +: SAMPLE_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      lane_mem[0] <= '0;
      lane_mem[1] <= '0;
    end else begin
      if (store) begin
        // A bypassed word whose first lane left this cycle resumes at the next lane.
        lane_mem[wr_ptr] <= (bypass && pop) ? cur_lane + 1'b1 : push_lane;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (lane_step) lane_mem[rd_ptr] <= cur_lane + 1'b1;
      if (retire)    rd_ptr <= next_ptr(rd_ptr);
      count <= count_next;
    end
  end

  // NOTE: word storage has no reset; count gates every read, so stale
  // contents are never observed and the array maps to plain storage.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sampleToAdx.sv
// -----------------------------------------------------------------------------
// sampleToAdx
// Converts a sample index into the word-aligned DRAM address of the 128-bit
// word holding it: adx = (sample / lanes) * step, truncated to ADX_WIDTH so the
// address wraps silently.
// Ports:
//   sample  in   32          sample index
//   adx     out  ADX_WIDTH   memory address (low bits zero)
// -----------------------------------------------------------------------------
module sampleToAdx #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int MEM_IF_WIDTH        = 128,
  parameter int ADX_WIDTH           = 27,
  parameter int MEMORY_WORD_WIDTH   = 2
) (
  input  logic [31:0]          sample,
  output logic [ADX_WIDTH-1:0] adx
);

  localparam int LANE_SHIFT = $clog2(MEM_IF_WIDTH / SAMPLE_PACKET_WIDTH);
  localparam int ADX_SHIFT  = $clog2(MEM_IF_WIDTH / 8 / MEMORY_WORD_WIDTH);

  assign adx = ADX_WIDTH'((sample >> LANE_SHIFT) << ADX_SHIFT);

endmodule

// File: rtl/dram_unpacker.sv
// -----------------------------------------------------------------------------
// dram_unpacker
// Fetches 128-bit words from the DRAM read port and streams them out as
// 32-bit samples over valid/ready, starting at lane first_sample[1:0] of the
// first word and stopping after num_samples samples.
// Build option: DRAM_UNPACKER_PREFETCH_EN selects a two-word buffer so the
// next word is requested as soon as the current one is loaded; otherwise a
// one-word buffer requests the next word only after the last lane leaves.
// Ports:
//   clk, reset        in   clock, synchronous active-high reset
//   start             in   transfer start pulse (ignored while busy)
//   first_sample      in   index of first sample
//   num_samples       in   number of samples
//   busy / done       out  transfer in progress / 1-cycle completion pulse
//   sample_data/valid out  registered sample stream
//   sample_ready      in   consumer ready
//   dram_adx          out  registered word-aligned read address
//   read_req          out  read command (only while read_allowed)
//   read_allowed      in   memory interface accepts a command this cycle
//   read_data/valid   in   read return word and its 1-cycle strobe
// -----------------------------------------------------------------------------
module dram_unpacker
  import dram_if_pkg::*;
#(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int MEM_IF_WIDTH        = 128,
  parameter int ADX_WIDTH           = 27,
  parameter int MEMORY_WORD_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [31:0]                    first_sample,
  input  logic [31:0]                    num_samples,
  output logic                           busy,
  output logic                           done,
  output logic [SAMPLE_PACKET_WIDTH-1:0] sample_data,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic [ADX_WIDTH-1:0]           dram_adx,
  output logic                           read_req,
  input  logic                           read_allowed,
  input  logic [MEM_IF_WIDTH-1:0]        read_data,
  input  logic                           read_data_valid
);

`ifdef DRAM_UNPACKER_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  fetch_state_t state, state_next;

  logic [31:0]           fetch_sample;  // aligned first sample of the last-addressed word
  logic [31:0]           words_left;    // words not yet requested
  logic [31:0]           to_load;       // samples not yet moved into the output register
  logic [31:0]           to_hs;         // samples not yet handed off
  logic                  first_word;
  logic [LANE_W-1:0]     first_lane;
  logic [33:0]           span;
  logic [31:0]           adx_in;
  logic [ADX_WIDTH-1:0]  adx_next;

  logic start_acc, push, load, hs, more_words;
  logic avail, slot_free;
  logic [SAMPLE_PACKET_WIDTH-1:0] head_sample;

  assign start_acc  = start && !busy;
  // A strobe with nothing outstanding (e.g. a response that straddled reset) is dropped.
  assign push       = read_data_valid && (state == F_WAIT);
  assign hs         = sample_valid && sample_ready;
  assign load       = avail && (!sample_valid || sample_ready) && (to_load != 32'd0);
  assign more_words = (words_left != 32'd0);
  assign span       = {2'b00, num_samples} + 34'(first_sample[1:0]) + 34'(LANES - 1);
  assign adx_in     = start_acc ? first_sample : fetch_sample + 32'(LANES);

  sampleToAdx #(
    .SAMPLE_PACKET_WIDTH (SAMPLE_PACKET_WIDTH),
    .MEM_IF_WIDTH        (MEM_IF_WIDTH),
    .ADX_WIDTH           (ADX_WIDTH),
    .MEMORY_WORD_WIDTH   (MEMORY_WORD_WIDTH)
  ) u_adx (
    .sample (adx_in),
    .adx    (adx_next)
  );

  dram_word_buffer #(
    .DEPTH    (BUF_DEPTH),
    .WORD_W   (MEM_IF_WIDTH),
    .SAMPLE_W (SAMPLE_PACKET_WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (read_data),
    .push_lane   (first_word ? first_lane : LANE_W'(0)),
    .pop         (load),
    .pop_last    (to_load == 32'd1),
    .avail       (avail),
    .slot_free   (slot_free),
    .head_sample (head_sample)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= F_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    read_req   = 1'b0;
    case (state)
      F_IDLE: begin
        if (start_acc && (num_samples != 32'd0)) state_next = F_REQ;
        else if (busy && more_words && slot_free) state_next = F_REQ;
      end
      F_REQ: begin
        read_req = read_allowed;
        if (read_allowed) state_next = F_WAIT;
      end
      F_WAIT: begin
        if (read_data_valid) state_next = (more_words && slot_free) ? F_REQ : F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      dram_adx     <= '0;
      fetch_sample <= '0;
      words_left   <= '0;
      to_load      <= '0;
      to_hs        <= '0;
      first_word   <= 1'b0;
      first_lane   <= '0;
    end else begin
      done <= 1'b0;

      if (start_acc) begin
        fetch_sample <= {first_sample[31:2], 2'b00};
        dram_adx     <= adx_next;
        first_lane   <= first_sample[1:0];
        first_word   <= 1'b1;
        words_left   <= 32'(span >> LANE_W);
        to_load      <= num_samples;
        to_hs        <= num_samples;
        busy         <= (num_samples != 32'd0);
        done         <= (num_samples == 32'd0);
      end

      // Issued only while busy, so never in the same cycle as an accepted start.
      if (read_req) begin
        fetch_sample <= fetch_sample + 32'(LANES);
        dram_adx     <= adx_next;
        words_left   <= words_left - 32'd1;
      end

      if (push) first_word <= 1'b0;

      if (load) begin
        sample_data  <= head_sample;
        sample_valid <= 1'b1;
        to_load      <= to_load - 32'd1;
      end else if (hs) begin
        sample_valid <= 1'b0;
      end

      if (hs) begin
        to_hs <= to_hs - 32'd1;
        if (to_hs == 32'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_unpacker.sv
// -----------------------------------------------------------------------------
// tb_dram_unpacker
// Self-checking bench for dram_unpacker: a latency-programmable memory model
// answers read commands, a scoreboard holds expected samples and addresses,
// and a negedge monitor compares the stream against it.
// -----------------------------------------------------------------------------
module tb_dram_unpacker;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  first_sample, num_samples;
  logic         busy, done;
  logic [31:0]  sample_data;
  logic         sample_valid;
  logic         sample_ready = 1'b1;
  logic [26:0]  dram_adx;
  logic         read_req;
  logic         read_allowed;
  logic [127:0] read_data = '0;
  logic         read_data_valid = 1'b0;

  int n_vec = 0, n_bad = 0;
  int done_cnt = 0, req_cnt = 0, hs_cnt = 0;
  int lat = 3;
  int rdy_mode = 0;
  int resp_cnt = 0;
  logic [26:0] resp_adx = '0;

  logic [31:0] exp_q[$];
  logic [26:0] adx_q[$];

`ifdef DRAM_UNPACKER_PREFETCH_EN
  localparam int BUF_WORDS = 2;
`else
  localparam int BUF_WORDS = 1;
`endif

  dram_unpacker dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .first_sample    (first_sample),
    .num_samples     (num_samples),
    .busy            (busy),
    .done            (done),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .dram_adx        (dram_adx),
    .read_req        (read_req),
    .read_allowed    (read_allowed),
    .read_data       (read_data),
    .read_data_valid (read_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] samp_val(input logic [31:0] i);
    return (i * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] make_word(input logic [26:0] adx);
    logic [127:0] w;
    logic [31:0]  widx;
    widx = 32'(adx >> 3);
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = samp_val(widx * 4 + 32'(k));
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic queue_xfer(input logic [31:0] f, input logic [31:0] n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(samp_val(f + 32'(i)));
    if (n != 0)
      for (int unsigned w = f >> 2; w <= ((f + n - 1) >> 2); w++) adx_q.push_back(27'(w * 8));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] f, input logic [31:0] n);
    start        = 1'b1;
    first_sample = f;
    num_samples  = n;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) tick();
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("samples_drained", 64'(exp_q.size()), 64'd0);
    check("reads_issued", 64'(adx_q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_req"}, 64'(read_req), 64'd0);
    check({tag, "_data"}, 64'(sample_data), 64'd0);
    check({tag, "_adx"}, 64'(dram_adx), 64'd0);
  endtask

  // Consumer ready: 0 = always, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       sample_ready = 1'b1;
      1:       sample_ready = 1'($urandom_range(0, 1));
      default: sample_ready = 1'b0;
    endcase
  end

  // Memory model: a command seen at a negedge is accepted at the next posedge;
  // the word returns `lat` cycles later. A pending response survives reset.
  always @(negedge clk) begin
    read_data_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        read_data_valid = 1'b1;
        read_data       = make_word(resp_adx);
      end
    end
    if (read_req && !reset) begin
      resp_cnt = lat;
      resp_adx = dram_adx;
    end
  end

  // Stream and command monitor.
  logic        stall_prev = 1'b0;
  logic        last_hs    = 1'b0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      last_hs    = 1'b0;
    end else begin
      if (last_hs) begin
        check("done_after_last", 64'(done), 64'd1);
        check("busy_fall", 64'(busy), 64'd0);
        last_hs = 1'b0;
      end
      if (stall_prev) begin
        check("hold_valid", 64'(sample_valid), 64'd1);
        check("hold_data", 64'(sample_data), 64'(prev_data));
      end
      if (done) done_cnt++;
      if (read_req) begin
        req_cnt++;
        if (adx_q.size() == 0) check("adx_extra", 64'(adx_q.size()), 64'd1);
        else                   check("dram_adx", 64'(dram_adx), 64'(adx_q.pop_front()));
      end
      if (sample_valid && sample_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("sample_extra", 64'(exp_q.size()), 64'd1);
        else begin
          check("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
          if (exp_q.size() == 0) last_hs = 1'b1;
        end
      end
      stall_prev = sample_valid && !sample_ready;
      prev_data  = sample_data;
    end
  end

  initial begin
    int r0, h0, d0;
    reset        = 1'b1;
    start        = 1'b0;
    first_sample = '0;
    num_samples  = '0;
    read_allowed = 1'b1;
    repeat (3) tick();
    check_reset_values("rst");
    tick();
    reset = 1'b0;
    tick();

    // Aligned 8-sample transfer: adx 0 then 8, read_req the cycle after start.
    queue_xfer(0, 8);
    pulse_start(0, 8);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_req_latency", 64'(read_req), 64'd1);
    wait_done(100);

    // Unaligned start crossing a word: lanes 2,3 of word 1 then lane 0 of word 2.
    queue_xfer(6, 3);
    pulse_start(6, 3);
    wait_done(100);

    // Zero-length transfer.
    r0 = req_cnt;
    pulse_start(0, 0);
    @(negedge clk);
    check("t3_done", 64'(done), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_req", 64'(read_req), 64'd0);
    tick();
    @(negedge clk);
    check("t3_done_clear", 64'(done), 64'd0);
    check("t3_busy_low", 64'(busy), 64'd0);
    repeat (5) tick();
    check("t3_no_read", 64'(req_cnt - r0), 64'd0);

    // Command port blocked for 5 cycles.
    read_allowed = 1'b0;
    queue_xfer(40, 6);
    pulse_start(40, 6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_req_blocked", 64'(read_req), 64'd0);
      tick();
    end
    read_allowed = 1'b1;
    @(negedge clk);
    check("t4_req_first_allowed", 64'(read_req), 64'd1);
    wait_done(200);

    // Random back-pressure, plus a start while busy that must be ignored.
    rdy_mode = 1;
    lat      = 2;
    queue_xfer(13, 37);
    pulse_start(13, 37);
    repeat (4) tick();
    pulse_start(100, 5);
    wait_done(2000);
    rdy_mode = 0;

    // Consumer stalled: count reads issued before any handoff.
    rdy_mode = 2;
    lat      = 3;
    r0       = req_cnt;
    h0       = hs_cnt;
    queue_xfer(0, 8);
    pulse_start(0, 8);
    repeat (15) tick();
    check("reads_before_handoff", 64'(req_cnt - r0), 64'(BUF_WORDS));
    check("no_handoff_stalled", 64'(hs_cnt - h0), 64'd0);
    rdy_mode = 0;
    wait_done(200);

    // Reset while a read is outstanding; its strobe arrives after reset.
    lat = 8;
    queue_xfer(20, 4);
    pulse_start(20, 4);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    adx_q.delete();
    check_reset_values("abort");
    d0 = done_cnt;
    h0 = hs_cnt;
    repeat (10) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("stale_dropped", 64'(hs_cnt - h0), 64'd0);
    check("abort_valid_low", 64'(sample_valid), 64'd0);

    // Recovery transfer must not see the stale word.
    lat = 3;
    queue_xfer(4, 4);
    pulse_start(4, 4);
    wait_done(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
